threshold_seq: RTL and testbench

//  Multi-cycle sequencer that drives the shared ALU/ALUCTRL pair to apply the custom threshold

---
 rtl/threshold_seq_if.sv | 30 +++
 rtl/threshold_seq.sv | 139 +++++++++++++
 tb/tb_threshold_seq.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/threshold_seq_if.sv
// Memory port and ALU/ALUCTRL hookup shared by the threshold sequencer.
// The master side is the sequencer; the slave side is the memory and ALU.
interface threshold_seq_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_rd_en;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_wr_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [4:0]        alu_op;
    logic [5:0]        alu_funct;
    logic [4:0]        alu_shamt;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_r;

    modport master (
        output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        output alu_op, alu_funct, alu_shamt, alu_a, alu_b,
        input  mem_rdata, alu_r
    );

    modport slave (
        input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
        input  alu_op, alu_funct, alu_shamt, alu_a, alu_b,
        output mem_rdata, alu_r
    );
endinterface

// File: rtl/threshold_seq.sv
// Sequences the shared ALU through the threshold instruction over a pixel buffer:
// read src[idx], compare against threshold in the ALU, write 255/0 to dst[idx].
//
// state | meaning
// IDLE  | waiting for start; job parameters latched on accepted start
// RD    | memory read strobe for src+idx
// WT    | read data returns; captured into the pixel register
// EX    | ALU runs the threshold op; result captured, n_above updated
// WR    | result written to dst+idx; idx advances
// DONE  | one-cycle done pulse, then back to IDLE
module threshold_seq #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] src_base_i,
    input  logic [ADDR_W-1:0] dst_base_i,
    input  logic [CNT_W-1:0]  count_i,
    input  logic [DATA_W-1:0] threshold_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [CNT_W-1:0]  n_above_o,
    threshold_seq_if.master   bus
);
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WT   = 3'd2;
    localparam logic [2:0] S_EX   = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] thr_q, thr_d;
    logic [DATA_W-1:0] pix_q, pix_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic [CNT_W-1:0]  nab_q, nab_d;

    logic rd_en;
    logic wr_en;

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        thr_d   = thr_q;
        pix_d   = pix_q;
        res_d   = res_q;
        nab_d   = nab_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !abort_i) begin
                    src_d   = src_base_i;
                    dst_d   = dst_base_i;
                    cnt_d   = count_i;
                    thr_d   = threshold_i;
                    idx_d   = '0;
                    nab_d   = '0;
                    state_d = (count_i == '0) ? S_DONE : S_RD;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                pix_d   = bus.mem_rdata;
                state_d = S_EX;
            end
            S_EX: begin
                res_d = bus.alu_r;
                if (bus.alu_r == DATA_W'(255) && nab_q != {CNT_W{1'b1}}) begin
                    nab_d = nab_q + CNT_W'(1);
                end
                state_d = S_WR;
            end
            S_WR: begin
                idx_d   = idx_q + CNT_W'(1);
                state_d = (idx_q + CNT_W'(1) == cnt_q) ? S_DONE : S_RD;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort only redirects the FSM; partial n_above stays visible.
        if (abort_i && state_q != S_IDLE) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            thr_q   <= '0;
            pix_q   <= '0;
            res_q   <= '0;
            nab_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            thr_q   <= thr_d;
            pix_q   <= pix_d;
            res_q   <= res_d;
            nab_q   <= nab_d;
        end
    end

    // Write strobe is gated by abort in the same cycle so an aborted WR never lands.
    assign rd_en = (state_q == S_RD);
    assign wr_en = (state_q == S_WR) && !abort_i;

    assign bus.mem_rd_en = rd_en;
    assign bus.mem_wr_en = wr_en;
    assign bus.mem_addr  = rd_en ? (src_q + ADDR_W'(idx_q)) :
                           wr_en ? (dst_q + ADDR_W'(idx_q)) : '0;
    assign bus.mem_wdata = wr_en ? res_q : '0;

    assign bus.alu_op    = (state_q == S_EX) ? 5'h02 : 5'h00;
    assign bus.alu_funct = (state_q == S_EX) ? 6'h32 : 6'h00;
    assign bus.alu_shamt = 5'd0;
    assign bus.alu_a     = pix_q;
    assign bus.alu_b     = thr_q;

    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = (state_q == S_DONE);
    assign n_above_o = nab_q;
endmodule

// File: tb/tb_threshold_seq.sv
// Scoreboard bench for threshold_seq: a job-level reference model queues the expected
// reads, writes and done events; a negedge monitor pops and compares them.
module tb_threshold_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start, abort;
    logic [15:0] src_base, dst_base, count;
    logic [31:0] threshold;
    logic        busy, done;
    logic [15:0] n_above;

    always #5 clk = ~clk;

    threshold_seq_if #(.ADDR_W(16), .DATA_W(32)) bus ();

    threshold_seq #(.ADDR_W(16), .DATA_W(32), .CNT_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .src_base_i  (src_base),
        .dst_base_i  (dst_base),
        .count_i     (count),
        .threshold_i (threshold),
        .busy_o      (busy),
        .done_o      (done),
        .n_above_o   (n_above),
        .bus         (bus)
    );

    // External memory (1-cycle read latency) and the ALU executing the threshold op.
    logic [31:0] mem [0:65535];
    always @(posedge clk) begin
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
    end
    assign bus.alu_r = (bus.alu_op == 5'h02 && bus.alu_funct == 6'h32 && bus.alu_a > bus.alu_b)
                       ? 32'd255 : 32'd0;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int rd_cnt = 0, wr_cnt = 0, done_cnt = 0;

    logic [15:0] rd_q [$];
    logic [47:0] wr_q [$];
    logic [47:0] done_q [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        logic [47:0] e;
        if (rst_n) begin
            check("strobe_excl", {31'd0, bus.mem_rd_en & bus.mem_wr_en}, 0);
            if (!bus.mem_rd_en && !bus.mem_wr_en) check("idle_addr", bus.mem_addr, 0);
            if (bus.mem_rd_en) begin
                rd_cnt++;
                if (rd_q.size() == 0) check("unexpected_read", rd_q.size(), 1);
                else begin
                    e[15:0] = rd_q.pop_front();
                    check("rd_addr", bus.mem_addr, e[15:0]);
                end
            end
            if (bus.mem_wr_en) begin
                wr_cnt++;
                if (wr_q.size() == 0) check("unexpected_write", wr_q.size(), 1);
                else begin
                    e = wr_q.pop_front();
                    check("wr_addr", bus.mem_addr, e[47:32]);
                    check("wr_data", bus.mem_wdata, e[31:0]);
                end
            end
            if (done) begin
                done_cnt++;
                check("done_busy", busy, 1);
                if (done_q.size() == 0) check("unexpected_done", done_q.size(), 1);
                else begin
                    e = done_q.pop_front();
                    check("done_n_above", n_above, e[15:0]);
                    check("done_cycle", cyc, e[47:16]);
                end
            end
        end
    end

    // Reference model: whole job computed up front, overlap handled by an overlay of
    // results already written earlier in the same job.
    task automatic start_job(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n,
                             input logic [31:0] t, output int s_cyc);
        logic [31:0] ov [logic [15:0]];
        logic [31:0] pix, r;
        logic [15:0] ra, wa, nab;
        @(posedge clk); #1;
        src_base = s; dst_base = d; count = n; threshold = t; start = 1'b1;
        s_cyc = cyc + 1;
        nab = 0;
        for (int i = 0; i < int'(n); i++) begin
            ra  = s + 16'(i);
            pix = ov.exists(ra) ? ov[ra] : mem[ra];
            r   = (pix > t) ? 32'd255 : 32'd0;
            wa  = d + 16'(i);
            ov[wa] = r;
            rd_q.push_back(ra);
            wr_q.push_back({wa, r});
            if (r == 32'd255 && nab != 16'hFFFF) nab++;
        end
        done_q.push_back({32'(s_cyc + ((n == 0) ? 0 : 4 * int'(n))), nab});
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int d0 = done_cnt;
        int k = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            k++;
        end
        check("done_seen", done_cnt - d0, 1);
        @(posedge clk); #1;
        check("busy_after_done", busy, 0);
        check("rd_q_empty", rd_q.size(), 0);
        check("wr_q_empty", wr_q.size(), 0);
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic flush();
        rd_q.delete();
        wr_q.delete();
        done_q.delete();
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_n_above"}, n_above, 0);
        check({tag, "_addr"}, bus.mem_addr, 0);
        check({tag, "_rd_en"}, bus.mem_rd_en, 0);
        check({tag, "_wr_en"}, bus.mem_wr_en, 0);
        check({tag, "_wdata"}, bus.mem_wdata, 0);
        check({tag, "_alu_op"}, bus.alu_op, 0);
        check({tag, "_alu_funct"}, bus.alu_funct, 0);
        check({tag, "_alu_shamt"}, bus.alu_shamt, 0);
        check({tag, "_alu_a"}, bus.alu_a, 0);
        check({tag, "_alu_b"}, bus.alu_b, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, w0, r0, d0, n;
        start = 0; abort = 0; src_base = 0; dst_base = 0; count = 0; threshold = 0;
        for (int i = 0; i < 65536; i++) mem[i] = $urandom_range(0, 255);

        repeat (3) @(posedge clk);
        #1 check_zero("reset");
        rst_n = 1'b1;

        // Directed job: three pixels against 128.
        mem[16'h10] = 150; mem[16'h11] = 100; mem[16'h12] = 128;
        start_job(16'h10, 16'h20, 16'd3, 32'd128, s);
        wait_done(30);
        check("t1_dst0", mem[16'h20], 255);
        check("t1_dst1", mem[16'h21], 0);
        check("t1_dst2", mem[16'h22], 0);
        check("t1_n_above", n_above, 1);

        // Empty job.
        w0 = wr_cnt; r0 = rd_cnt;
        start_job(16'h100, 16'h200, 16'd0, 32'd5, s);
        wait_done(5);
        check("t2_no_writes", wr_cnt - w0, 0);
        check("t2_no_reads", rd_cnt - r0, 0);
        check("t2_n_above", n_above, 0);

        // Address wrap.
        start_job(16'hFFFF, 16'hFFFE, 16'd2, 32'd60, s);
        wait_done(20);

        // Abort in the second WR.
        w0 = wr_cnt;
        start_job(16'h30, 16'h40, 16'd4, 32'd100, s);
        wait_cyc(s + 7);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check("t4_busy_after_abort", busy, 0);
        check("t4_one_write", wr_cnt - w0, 1);
        flush();
        d0 = done_cnt;
        repeat (10) @(posedge clk);
        #1 check("t4_no_done", done_cnt - d0, 0);
        start_job(16'h30, 16'h48, 16'd3, 32'd90, s);
        wait_done(30);

        // Abort together with start in IDLE.
        @(posedge clk); #1;
        start = 1'b1; abort = 1'b1; count = 16'd2;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        check("abort_beats_start", busy, 0);

        // Reset pulse in EX.
        start_job(16'h50, 16'h60, 16'd3, 32'd10, s);
        wait_cyc(s + 2);
        rst_n = 1'b0;
        #1 check_zero("rst_mid");
        @(posedge clk); #1;
        rst_n = 1'b1;
        flush();
        start_job(16'h50, 16'h60, 16'd3, 32'd10, s);
        wait_done(30);

        // Second start mid-job is ignored.
        w0 = wr_cnt; d0 = done_cnt;
        start_job(16'h70, 16'h80, 16'd2, 32'd128, s);
        wait_cyc(s + 4);
        src_base = 16'h900; dst_base = 16'h910; count = 16'd5; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(20);
        repeat (10) @(posedge clk);
        #1;
        check("t6_two_writes", wr_cnt - w0, 2);
        check("t6_one_done", done_cnt - d0, 1);

        // Randomized jobs with overlapping and wrapping windows.
        for (int j = 0; j < 25; j++) begin
            logic [15:0] sb, db;
            n  = $urandom_range(0, 7);
            sb = 16'($urandom_range(0, 40)) - ((j % 3 == 0) ? 16'd20 : 16'd0);
            db = sb + 16'($urandom_range(0, 12)) - 16'd6;
            start_job(sb, db, 16'(n), 32'($urandom_range(0, 255)), s);
            wait_done(4 * n + 10);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
